// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and FSM encoding.
package uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_EMPTY = 1;
    localparam int unsigned STAT_BUSY  = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_IRQ   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // A divider of zero would never reach a bit boundary, so run it as one.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-derived full/empty; a push and a pop in the
// same cycle while full is accepted.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = count_q == FullCnt;
    assign empty   = count_q == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: store port pushes bytes into a TX FIFO,
// a bit-timer FSM serialises them on tx.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        sel,
    output logic        tx,
    output logic        irq
);

    import uart_pkg::*;

    logic [1:0]  off;
    logic        wr_en, push, pop, load;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [15:0] baud_q, baud_d;
    logic        ovf_q, ovf_d;
    uart_state_e state_q, state_d;
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d, irq_q, irq_d;
    logic        busy, bit_end;
    logic        unused_bits;

    assign sel         = A[31:4] == BASE_ADDR[31:4];
    assign off         = A[3:2];
    assign wr_en       = WE & sel;
    assign push        = wr_en & (off == OFF_TXDATA);
    assign busy        = state_q != StIdle;
    assign bit_end     = cnt_q == div_q - 16'd1;
    assign tx          = tx_q;
    assign irq         = irq_q;
    assign unused_bits = ^{WD[31:16], A[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .areset (areset),
        .push   (push),
        .pop    (pop),
        .din    (WD[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        baud_d = baud_q;
        ovf_d  = ovf_q;
        if (wr_en && off == OFF_BAUDDIV) baud_d = WD[15:0];
        if (wr_en && off == OFF_STATUS && WD[STAT_OVF]) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        load      = 1'b0;
        irq_d     = fifo_empty & ~busy;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) load = 1'b1;
            end
            StStart: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d     = '0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_q + 16'd1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (!fifo_empty) load = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Divider is captured per frame so BAUDDIV writes never disturb a frame in flight.
        if (load) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            div_d   = eff_div(baud_q);
            cnt_d   = '0;
            tx_d    = 1'b0;
            state_d = StStart;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            baud_q    <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
            state_q   <= StIdle;
            div_q     <= eff_div(DEFAULT_DIV);
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
        end else begin
            baud_q    <= baud_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        RD = '0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    RD[STAT_IRQ]   = irq_q;
                    RD[STAT_OVF]   = ovf_q;
                    RD[STAT_BUSY]  = busy;
                    RD[STAT_EMPTY] = fifo_empty;
                    RD[STAT_FULL]  = fifo_full;
                end
                OFF_BAUDDIV: RD = {16'd0, baud_q};
                default:     RD = '0;
            endcase
        end
    end

endmodule
